// File: rtl/key_repeat.sv
// ============================================================================
// key_repeat
// ----------------------------------------------------------------------------
// Turns the debounced, held-level button signal into single-cycle key events
// for the calculator control FSM. A new press gives one press pulse. If the
// button stays down, the first auto-repeat comes REPEAT_DELAY cycles later and
// the following repeats come every REPEAT_RATE cycles. The block also reports
// the end of a hold, a held flag and a saturating repeat count, which the
// control FSM uses for digit entry and acceleration.
//
// A button that is already down when reset is released produces no event
// until it has been seen released once (WAIT_REL state).
//
// Ports:
//   clk          system clock
//   rst_n        asynchronous reset, active-low
//   deb          debounced button level, synchronous to clk, 1 = pressed
//   key_evt      one-cycle pulse: press OR repeat
//   press        one-cycle pulse on a new press
//   rpt          one-cycle pulse on each auto-repeat
//   release_evt  one-cycle pulse when a tracked hold ends. The port is not
//                called "release" because that word is a reserved keyword.
//   held         1 while the FSM is in DELAY or REPEAT
//   rpt_cnt      repeats since the last press, saturating at 255
//
// Parameters:
//   REPEAT_DELAY  cycles from the press pulse to the first repeat (>= 1)
//   REPEAT_RATE   cycles between later repeat pulses (>= 1)
//   REPEAT_EN     1 = auto-repeat on; 0 = no repeats, the hold is still tracked
//   CNT_W         timer width, must hold max(REPEAT_DELAY, REPEAT_RATE) - 1
//
// All outputs are registered. Each one is computed from the next-state
// decision and loaded on the same edge as the state register, so the pulses,
// held and rpt_cnt always line up with the state they describe.
// ============================================================================
module key_repeat #(
    parameter int REPEAT_DELAY = 50000000,
    parameter int REPEAT_RATE  = 10000000,
    parameter int REPEAT_EN    = 1,
    parameter int CNT_W        = 27
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       deb,
    output logic       key_evt,
    output logic       press,
    output logic       rpt,
    output logic       release_evt,
    output logic       held,
    output logic [7:0] rpt_cnt
);

    typedef enum logic [1:0] {
        WAIT_REL = 2'd0,   // waiting for the first release after reset
        IDLE     = 2'd1,   // button up, ready for a press
        DELAY    = 2'd2,   // held, counting toward the first repeat
        REPEAT   = 2'd3    // held, repeating at the fixed rate
    } state_t;

    // Terminal timer values. The timer counts 0 .. N-1, so a terminal count
    // is reached exactly N cycles after the timer was last cleared.
    localparam logic [CNT_W-1:0] DELAY_LAST = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] RATE_LAST  = CNT_W'(REPEAT_RATE - 1);
    localparam logic [7:0]       CNT_MAX    = 8'd255;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] timer;
    logic [CNT_W-1:0] timer_nxt;

    // Next values of the registered outputs.
    logic       press_nxt;
    logic       rpt_nxt;
    logic       release_nxt;
    logic       held_nxt;
    logic       key_evt_nxt;
    logic [7:0] rpt_cnt_nxt;

    // ------------------------------------------------------------------------
    // State register. The timer and all outputs are loaded here too, so every
    // output is a flop.
    // ------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the values from before the edge, whatever order the statements
    // are in.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= WAIT_REL;
            timer       <= '0;
            press       <= 1'b0;
            rpt         <= 1'b0;
            release_evt <= 1'b0;
            held        <= 1'b0;
            key_evt     <= 1'b0;
            rpt_cnt     <= 8'd0;
        end else begin
            state       <= state_nxt;
            timer       <= timer_nxt;
            press       <= press_nxt;
            rpt         <= rpt_nxt;
            release_evt <= release_nxt;
            held        <= held_nxt;
            key_evt     <= key_evt_nxt;
            rpt_cnt     <= rpt_cnt_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state and timer logic. This also decides the pulse conditions,
    // because they are properties of the transition that is taken.
    // ------------------------------------------------------------------------
    // NOTE: every variable gets a default value at the top of the block, so
    // no path leaves one unassigned and no latch is inferred.
    always_comb begin
        state_nxt   = state;
        timer_nxt   = timer;
        press_nxt   = 1'b0;
        rpt_nxt     = 1'b0;
        release_nxt = 1'b0;

        case (state)
            WAIT_REL: begin
                if (!deb) begin
                    state_nxt = IDLE;
                end
            end

            IDLE: begin
                if (deb) begin
                    state_nxt = DELAY;
                    timer_nxt = '0;
                    press_nxt = 1'b1;
                end
            end

            DELAY: begin
                // A release seen on the terminal cycle wins over the repeat.
                if (!deb) begin
                    state_nxt   = IDLE;
                    release_nxt = 1'b1;
                end else if ((REPEAT_EN != 0) && (timer == DELAY_LAST)) begin
                    state_nxt = REPEAT;
                    timer_nxt = '0;
                    rpt_nxt   = 1'b1;
                end else if (timer != DELAY_LAST) begin
                    // With repeat disabled the timer parks at its terminal
                    // value and the FSM stays in DELAY for the whole hold.
                    timer_nxt = timer + 1'b1;
                end
            end

            REPEAT: begin
                if (!deb) begin
                    state_nxt   = IDLE;
                    release_nxt = 1'b1;
                end else if (timer == RATE_LAST) begin
                    timer_nxt = '0;
                    rpt_nxt   = 1'b1;
                end else begin
                    timer_nxt = timer + 1'b1;
                end
            end

            default: begin
                state_nxt = WAIT_REL;
                timer_nxt = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Output logic: values that go into the output flops.
    // ------------------------------------------------------------------------
    always_comb begin
        key_evt_nxt = press_nxt | rpt_nxt;

        // held follows the state being entered, so it rises together with
        // press and falls together with release_evt.
        held_nxt = (state_nxt == DELAY) || (state_nxt == REPEAT);

        // The count is cleared only by a press and keeps its value after a
        // release, so the control FSM can still read it.
        rpt_cnt_nxt = rpt_cnt;
        if (press_nxt) begin
            rpt_cnt_nxt = 8'd0;
        end else if (rpt_nxt && (rpt_cnt != CNT_MAX)) begin
            rpt_cnt_nxt = rpt_cnt + 8'd1;
        end
    end

endmodule

// File: tb/tb_key_repeat.sv
// ============================================================================
// tb_key_repeat
// ----------------------------------------------------------------------------
// Self-checking bench for key_repeat. Two instances are built with
// REPEAT_DELAY=10 and REPEAT_RATE=4: u0 has auto-repeat on and u1 has it off.
// Both share deb and rst_n.
//
// Each instance has a behavioural model. The model keeps "edges since the
// press" and derives the repeats from that count arithmetically:
// k >= DELAY and (k - DELAY) % RATE == 0. A compare process checks every
// output of both instances against its model on every falling clock edge.
// Directed scenarios add hand-computed literal expectations, and a
// randomized phase follows them.
// ============================================================================
module tb_key_repeat;

    localparam int DLY  = 10;
    localparam int RATE = 4;

    logic clk;
    logic rst_n;
    logic deb;

    logic       key_evt0, press0, rpt0, rel0, held0;
    logic [7:0] cnt0;
    logic       key_evt1, press1, rpt1, rel1, held1;
    logic [7:0] cnt1;

    int n_checks = 0;
    int n_errors = 0;

    key_repeat #(.REPEAT_DELAY(DLY), .REPEAT_RATE(RATE), .REPEAT_EN(1), .CNT_W(8)) u0 (
        .clk(clk), .rst_n(rst_n), .deb(deb),
        .key_evt(key_evt0), .press(press0), .rpt(rpt0),
        .release_evt(rel0), .held(held0), .rpt_cnt(cnt0)
    );

    key_repeat #(.REPEAT_DELAY(DLY), .REPEAT_RATE(RATE), .REPEAT_EN(0), .CNT_W(8)) u1 (
        .clk(clk), .rst_n(rst_n), .deb(deb),
        .key_evt(key_evt1), .press(press1), .rpt(rpt1),
        .release_evt(rel1), .held(held1), .rpt_cnt(cnt1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        bit ready;     // deb has been seen low since reset or since the last hold
        bit holding;   // a press is being tracked
        int k;         // edges since the press edge
        bit press;
        bit rpt;
        bit rel;
        int cnt;
    } mdl_t;

    function automatic mdl_t mdl_reset();
        mdl_t m;
        m.ready = 0; m.holding = 0; m.k = 0;
        m.press = 0; m.rpt = 0; m.rel = 0; m.cnt = 0;
        return m;
    endfunction

    function automatic mdl_t mdl_step(mdl_t m, bit d, bit en);
        mdl_t n = m;
        n.press = 0; n.rpt = 0; n.rel = 0;
        if (!m.holding) begin
            if (d && m.ready) begin
                n.holding = 1; n.k = 0; n.press = 1; n.cnt = 0;
            end else if (!d) begin
                n.ready = 1;
            end
        end else if (!d) begin
            n.holding = 0; n.rel = 1; n.ready = 1;
        end else begin
            n.k = m.k + 1;
            if (en && n.k >= DLY && ((n.k - DLY) % RATE) == 0) begin
                n.rpt = 1;
                if (n.cnt < 255) n.cnt = n.cnt + 1;
            end
        end
        return n;
    endfunction

    mdl_t m0, m1;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m0 <= mdl_reset();
            m1 <= mdl_reset();
        end else begin
            m0 <= mdl_step(m0, deb, 1'b1);
            m1 <= mdl_step(m1, deb, 1'b0);
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        check("u0.press",   32'(press0),   32'(m0.press));
        check("u0.rpt",     32'(rpt0),     32'(m0.rpt));
        check("u0.release", 32'(rel0),     32'(m0.rel));
        check("u0.key_evt", 32'(key_evt0), 32'(m0.press | m0.rpt));
        check("u0.held",    32'(held0),    32'(m0.holding));
        check("u0.rpt_cnt", 32'(cnt0),     32'(m0.cnt));
        check("u1.press",   32'(press1),   32'(m1.press));
        check("u1.rpt",     32'(rpt1),     32'(m1.rpt));
        check("u1.release", 32'(rel1),     32'(m1.rel));
        check("u1.key_evt", 32'(key_evt1), 32'(m1.press | m1.rpt));
        check("u1.held",    32'(held1),    32'(m1.holding));
        check("u1.rpt_cnt", 32'(cnt1),     32'(m1.cnt));
    end

    // Drive deb for the next rising edge. The outputs read right after this
    // call come from the edge just before it.
    task automatic step(input logic d);
        @(negedge clk);
        deb = d;
    endtask

    // Async reset pulse between a rising edge and the following falling edge.
    task automatic reset_pulse(input bit check_zero);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        if (check_zero) begin
            check("rst.press",   32'(press0),   0);
            check("rst.rpt",     32'(rpt0),     0);
            check("rst.release", 32'(rel0),     0);
            check("rst.key_evt", 32'(key_evt0), 0);
            check("rst.held",    32'(held0),    0);
            check("rst.rpt_cnt", 32'(cnt0),     0);
        end
        #1 rst_n = 1'b1;
    endtask

    initial begin
        int cnt_exp;
        int n_held;
        int n_rel;
        int n_rpt;
        logic lvl;
        int len;

        rst_n = 1'b0;
        deb   = 1'b1;
        repeat (3) @(negedge clk);
        check("reset.key_evt", 32'(key_evt0), 0);
        check("reset.held",    32'(held0),    0);
        check("reset.rpt_cnt", 32'(cnt0),     0);
        rst_n = 1'b1;

        // 1: held through reset -> no event until released once
        for (int i = 0; i < 30; i++) begin
            step(1'b1);
            check("s1.no_press", 32'(press0), 0);
            check("s1.no_held",  32'(held0),  0);
        end
        step(1'b0);
        step(1'b0);

        // 2: press at i=1, repeats at i=11,15,19,23,27
        step(1'b1);
        cnt_exp = 0;
        for (int i = 1; i <= 30; i++) begin
            bit exp_r;
            step(1'b1);
            exp_r = (i == 11) || (i == 15) || (i == 19) || (i == 23) || (i == 27);
            if (exp_r) cnt_exp++;
            check("s2.press",   32'(press0),   32'(i == 1));
            check("s2.rpt",     32'(rpt0),     32'(exp_r));
            check("s2.key_evt", 32'(key_evt0), 32'((i == 1) || exp_r));
            check("s2.rpt_cnt", 32'(cnt0),     32'(cnt_exp));
            check("s2.en0_rpt", 32'(rpt1),     0);
            check("s2.en0_held", 32'(held1),   1);
        end
        check("s2.en0_cnt", 32'(cnt1), 0);
        repeat (3) step(1'b0);

        // 3: held 5 cycles -> one press, no rpt, release at i=6, held 5 cycles
        n_held = 0; n_rel = 0; n_rpt = 0;
        for (int i = 0; i < 10; i++) begin
            step(logic'(i < 5));
            if (i >= 1) begin
                n_held += int'(held0);
                n_rel  += int'(rel0);
                n_rpt  += int'(rpt0);
            end
            if (i == 6) check("s3.release", 32'(rel0), 1);
        end
        check("s3.held_cycles", 32'(n_held), 5);
        check("s3.releases",    32'(n_rel),  1);
        check("s3.rpts",        32'(n_rpt),  0);
        check("s3.rpt_cnt",     32'(cnt0),   0);

        // 4: drop on the first-repeat edge, re-raise the next cycle
        for (int i = 0; i < 14; i++) begin
            step(logic'((i < 10) || (i >= 11)));
            if (i == 11) begin
                check("s4.release", 32'(rel0),  1);
                check("s4.no_rpt",  32'(rpt0),  0);
                check("s4.held",    32'(held0), 0);
            end
            if (i == 12) check("s4.repress", 32'(press0), 1);
        end
        repeat (3) step(1'b0);

        // 5: long hold -> saturation at 255, repeats keep coming
        step(1'b1);
        n_rpt = 0;
        for (int i = 1; i <= DLY + RATE * 300 + 2; i++) begin
            step(1'b1);
            n_rpt += int'(rpt0);
        end
        check("s5.rpts",    32'(n_rpt), 301);
        check("s5.rpt_cnt", 32'(cnt0),  255);
        step(1'b0);
        step(1'b0);
        check("s5.cnt_kept", 32'(cnt0), 255);
        step(1'b1);
        step(1'b1);
        check("s5.press",     32'(press0), 1);
        check("s5.cnt_clear", 32'(cnt0),   0);

        // 6: reset during REPEAT with deb still high
        repeat (14) step(1'b1);
        check("s6.in_repeat", 32'(cnt0 != 8'd0), 1);
        reset_pulse(1'b1);
        for (int i = 0; i < 5; i++) begin
            step(1'b1);
            check("s6.no_press", 32'(press0), 0);
        end
        step(1'b0);
        step(1'b1);
        step(1'b1);
        check("s6.press", 32'(press0), 1);

        // randomized phase
        lvl = 1'b0;
        for (int r = 0; r < 300; r++) begin
            lvl = ~lvl;
            if ($urandom_range(0, 9) == 0) len = $urandom_range(20, 60);
            else len = $urandom_range(1, 16);
            for (int j = 0; j < len; j++) step(lvl);
            if ($urandom_range(0, 39) == 0) reset_pulse(1'b0);
        end

        repeat (3) step(1'b0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
